sum_accumulator: RTL and testbench

Sequential stage placed directly downstream of adder_6bits. It consumes the adder's 7-bit sum stream through a valid/ready handshake and accumulates a fixed-length burst of N sums into a wider running total. It presents the total, a sample count and a sticky overflow flag, then holds the result until downstream acknowledges it.

---
 rtl/sum_accumulator.sv | 108 ++++++++++
 tb/tb_sum_accumulator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Sums a fixed-length burst of N unsigned samples into an ACC_W-bit running total.
// The result and a sticky overflow flag are held until downstream acknowledges them.
module sum_accumulator #(
  parameter int SUM_W = 7,
  parameter int N     = 8,
  parameter int ACC_W = 10,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic [SUM_W-1:0] i_w_sum,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  output logic [ACC_W-1:0] o_w_acc,
  output logic [CNT_W-1:0] o_w_count,
  output logic             o_w_done,
  input  logic             i_w_ack,
  output logic             o_w_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;

  // One extra bit on the add captures the carry-out for the sticky flag.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(i_w_sum);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_w_start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          done_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      ACCUM: begin
        if (i_w_start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (i_w_valid && ready_q) begin
          acc_d = sum_ext[ACC_W-1:0];
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | sum_ext[ACC_W];
          if (cnt_q == CNT_W'(N-1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      DONE: begin
        // start is deliberately ignored here, even alongside ack
        if (i_w_ack) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_w_ready    = ready_q;
  assign o_w_acc      = acc_q;
  assign o_w_count    = cnt_q;
  assign o_w_done     = done_q;
  assign o_w_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed checks of sum_accumulator against a burst-level model
// tracking the unbounded arithmetic total; a 9-bit-accumulator instance exercises wrap.
module tb_sum_accumulator;

  localparam int N = 8;

  logic       clk, rst_n, start, valid, ack;
  logic [6:0] sum;
  logic       ready, done, ovf, ready9, done9, ovf9;
  logic [9:0] acc;
  logic [8:0] acc9;
  logic [3:0] count, count9;

  sum_accumulator #(.SUM_W(7), .N(N), .ACC_W(10)) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start), .i_w_sum(sum),
    .i_w_valid(valid), .o_w_ready(ready), .o_w_acc(acc), .o_w_count(count),
    .o_w_done(done), .i_w_ack(ack), .o_w_overflow(ovf));

  sum_accumulator #(.SUM_W(7), .N(N), .ACC_W(9)) dut9 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start), .i_w_sum(sum),
    .i_w_valid(valid), .o_w_ready(ready9), .o_w_acc(acc9), .o_w_count(count9),
    .o_w_done(done9), .i_w_ack(ack), .o_w_overflow(ovf9));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: phase 0 idle, 1 collecting, 2 result held. total is unbounded.
  int m_phase = 0;
  int m_total = 0;
  int m_cnt   = 0;
  bit m_done  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".acc"},   32'(acc),    32'(m_total % 1024));
    chk({tag, ".cnt"},   32'(count),  32'(m_cnt));
    chk({tag, ".done"},  32'(done),   32'(m_done));
    chk({tag, ".ready"}, 32'(ready),  32'(m_phase == 1));
    chk({tag, ".ovf"},   32'(ovf),    32'(m_total > 1023));
    chk({tag, ".acc9"},  32'(acc9),   32'(m_total % 512));
    chk({tag, ".ovf9"},  32'(ovf9),   32'(m_total > 511));
  endtask

  task automatic model_edge(input bit s, input bit v, input int x, input bit a);
    case (m_phase)
      0: if (s) begin m_total = 0; m_cnt = 0; m_done = 0; m_phase = 1; end
      1: if (s) begin m_total = 0; m_cnt = 0; end
         else if (v) begin
           m_total += x;
           m_cnt++;
           if (m_cnt == N) begin m_phase = 2; m_done = 1; end
         end
      default: if (a) begin m_phase = 0; m_done = 0; end
    endcase
  endtask

  task automatic cyc(input string tag, input bit s, input bit v, input int x, input bit a);
    start = s; valid = v; sum = 7'(x); ack = a;
    @(posedge clk);
    model_edge(s, v, x, a);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    m_phase = 0; m_total = 0; m_cnt = 0; m_done = 0;
  endtask

  initial begin
    int acc_n;
    rst_n = 1'b0; start = 0; valid = 0; ack = 0; sum = '0;
    #3;
    chk_all("reset");
    #9 rst_n = 1'b1;

    // stray valid/ack while idle
    cyc("idle_stray", 0, 1, 50, 1);

    // 1..8 back to back
    cyc("t1_start", 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc("t1_s", 0, 1, i, 0);
    chk("t1_acc36", 32'(acc), 32'd36);
    chk("t1_done", 32'(done), 32'd1);
    cyc("t1_hold", 0, 1, 9, 0);
    cyc("t1_ack", 0, 0, 0, 1);
    chk("t1_keep36", 32'(acc), 32'd36);

    // max-sum burst, wraps only in the 9-bit instance
    cyc("t2_start", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc("t2_s", 0, 1, 126, 0);
    chk("t2_acc1008", 32'(acc), 32'd1008);
    chk("t2_ovf0", 32'(ovf), 32'd0);
    chk("t2_acc9_496", 32'(acc9), 32'd496);
    chk("t2_ovf9_1", 32'(ovf9), 32'd1);
    cyc("t2_ack", 0, 0, 0, 1);

    // valid gaps stall the burst
    cyc("t3_start", 1, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      cyc("t3_s", 0, (i % 2) == 0, (i % 2) ? 99 : ((i % 4) == 0 ? 10 : 20), 0);
    chk("t3_acc120", 32'(acc), 32'd120);
    cyc("t3_ack", 0, 0, 0, 1);

    // restart mid-burst drops the sample offered with start
    cyc("t4_start", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4_s", 0, 1, 5, 0);
    cyc("t4_restart", 1, 1, 7, 0);
    chk("t4_acc0", 32'(acc), 32'd0);
    chk("t4_cnt0", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) cyc("t4_s1", 0, 1, 1, 0);
    chk("t4_acc8", 32'(acc), 32'd8);

    // start with ack in DONE: back to idle, no new burst
    cyc("t5_start_ack", 1, 0, 0, 1);
    chk("t5_ready0", 32'(ready), 32'd0);
    cyc("t5_idle", 0, 1, 3, 0);
    chk("t5_ready_stays0", 32'(ready), 32'd0);

    // async reset between edges mid-burst
    cyc("t6_start", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("t6_s", 0, 1, 11, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("t6_async_rst");
    #2 rst_n = 1'b1;
    cyc("t6_no_start", 0, 1, 5, 0);
    chk("t6_cnt0", 32'(count), 32'd0);

    // random traffic
    acc_n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
          int'($urandom_range(0, 126)), $urandom_range(0, 2) == 0);
      if (m_phase == 0 && $urandom_range(0, 3) == 0) begin
        cyc("rand_kick", 1, 0, 0, 0);
        acc_n++;
      end
    end
    chk("rand_bursts_started", 32'(acc_n > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
